// File: rtl/hazard_stall_ctrl.sv
// Stall/flush generator for the 5-stage pipeline: load-use bubbles, multdiv occupancy
// sequencing with a timeout watchdog, and taken-branch flushes.
module hazard_stall_ctrl #(
   parameter int unsigned MD_TIMEOUT = 40,
   parameter int unsigned CNT_W      = 6
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] FDinsn,
   input  logic [31:0] DXinsn,
   input  logic        flush,
   input  logic        multdiv_ready,
   input  logic        multdiv_exception,
   output logic        stall_FD,
   output logic        stall_DX,
   output logic        nop_FD,
   output logic        nop_DX,
   output logic        nop_XM,
   output logic        ctrl_MULT,
   output logic        ctrl_DIV,
   output logic        md_capture,
   output logic        md_timeout
);

   localparam logic [4:0] OpRType = 5'b00000;
   localparam logic [4:0] OpAddi  = 5'b00101;
   localparam logic [4:0] OpLw    = 5'b01000;
   localparam logic [4:0] OpSw    = 5'b00111;
   localparam logic [4:0] OpBne   = 5'b00010;
   localparam logic [4:0] OpBlt   = 5'b00110;
   localparam logic [4:0] OpJr    = 5'b00100;
   localparam logic [4:0] OpBex   = 5'b10110;
   localparam logic [4:0] AluMul  = 5'b00110;
   localparam logic [4:0] AluDiv  = 5'b00111;

   typedef enum logic [1:0] {StIdle, StWait, StDone} mdState_e;

   mdState_e         stateQ, stateD;
   logic [CNT_W-1:0] cntQ, cntD;
   logic             timeoutQ, timeoutD;

   logic [4:0] fdOp, fdRd, fdRs, fdRt;
   logic [4:0] dxOp, dxRd, dxAluOp;
   logic       dxIsLw, dxIsMul, dxIsDiv, dxIsMd;
   logic [4:0] srcA, srcB;
   logic       srcAValid, srcBValid;
   logic       hitA, hitB, loadUse;
   logic       unusedBits;

   assign fdOp    = FDinsn[31:27];
   assign fdRd    = FDinsn[26:22];
   assign fdRs    = FDinsn[21:17];
   assign fdRt    = FDinsn[16:12];
   assign dxOp    = DXinsn[31:27];
   assign dxRd    = DXinsn[26:22];
   assign dxAluOp = DXinsn[6:2];

   // Exception is latched by the datapath on md_capture; it does not affect sequencing.
   assign unusedBits = ^{FDinsn[11:0], DXinsn[21:7], DXinsn[1:0], multdiv_exception};

   assign dxIsLw  = (dxOp == OpLw);
   assign dxIsMul = (dxOp == OpRType) && (dxAluOp == AluMul);
   assign dxIsDiv = (dxOp == OpRType) && (dxAluOp == AluDiv);
   assign dxIsMd  = dxIsMul || dxIsDiv;

   always_comb begin
      srcA      = '0;
      srcB      = '0;
      srcAValid = 1'b0;
      srcBValid = 1'b0;
      case (fdOp)
         OpRType: begin
            srcA      = fdRs;
            srcB      = fdRt;
            srcAValid = 1'b1;
            srcBValid = 1'b1;
         end
         OpAddi, OpLw: begin
            srcA      = fdRs;
            srcAValid = 1'b1;
         end
         OpBne, OpBlt: begin
            srcA      = fdRd;
            srcB      = fdRs;
            srcAValid = 1'b1;
            srcBValid = 1'b1;
         end
         OpJr: begin
            srcA      = fdRd;
            srcAValid = 1'b1;
         end
         // Store data (rd) is covered by the M-stage bypass; only the address stalls.
         OpSw: begin
            srcA      = fdRs;
            srcAValid = 1'b1;
         end
         OpBex: begin
            srcA      = 5'd30;
            srcAValid = 1'b1;
         end
         default: ;
      endcase
   end

   assign hitA    = srcAValid && (srcA != 5'd0) && (srcA == dxRd);
   assign hitB    = srcBValid && (srcB != 5'd0) && (srcB == dxRd);
   assign loadUse = dxIsLw && (dxRd != 5'd0) && (hitA || hitB);

   always_comb begin
      stateD     = stateQ;
      cntD       = cntQ;
      timeoutD   = timeoutQ;
      stall_FD   = 1'b0;
      stall_DX   = 1'b0;
      nop_FD     = 1'b0;
      nop_DX     = 1'b0;
      nop_XM     = 1'b0;
      ctrl_MULT  = 1'b0;
      ctrl_DIV   = 1'b0;
      md_capture = 1'b0;
      if (reset) begin
         unique case (stateQ)
            StIdle: begin
               if (flush) begin
                  nop_FD = 1'b1;
                  nop_DX = 1'b1;
               end else if (dxIsMd) begin
                  ctrl_MULT = dxIsMul;
                  ctrl_DIV  = dxIsDiv;
                  stall_FD  = 1'b1;
                  stall_DX  = 1'b1;
                  nop_XM    = 1'b1;
                  cntD      = '0;
                  stateD    = StWait;
               end else if (loadUse) begin
                  stall_FD = 1'b1;
                  nop_DX   = 1'b1;
               end
            end
            // Flush and load-use are ignored here so the held mul/div survives.
            StWait: begin
               stall_FD = 1'b1;
               stall_DX = 1'b1;
               nop_XM   = 1'b1;
               cntD     = cntQ + CNT_W'(1);
               if (multdiv_ready) begin
                  md_capture = 1'b1;
                  stateD     = StDone;
               end else if (cntQ == CNT_W'(MD_TIMEOUT - 1)) begin
                  timeoutD   = 1'b1;
                  md_capture = 1'b1;
                  stateD     = StDone;
               end
            end
            StDone: begin
               stateD = StIdle;
               if (flush) begin
                  nop_FD = 1'b1;
                  nop_DX = 1'b1;
               end
            end
            default: stateD = StIdle;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         stateQ   <= StIdle;
         cntQ     <= '0;
         timeoutQ <= 1'b0;
      end else begin
         stateQ   <= stateD;
         cntQ     <= cntD;
         timeoutQ <= timeoutD;
      end
   end

   assign md_timeout = timeoutQ & reset;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: table of single-cycle hazard vectors plus multdiv sequences,
// with expected output vectors queued at drive time and compared mid-cycle.
module tb_hazard_stall_ctrl;

   localparam int MdTimeout = 40;

   localparam logic [4:0] OP_LW   = 5'b01000;
   localparam logic [4:0] OP_SW   = 5'b00111;
   localparam logic [4:0] OP_BNE  = 5'b00010;
   localparam logic [4:0] OP_JR   = 5'b00100;
   localparam logic [4:0] OP_ADDI = 5'b00101;
   localparam logic [4:0] OP_J    = 5'b00001;

   // Output vector order: stall_FD stall_DX nop_FD nop_DX nop_XM ctrl_MULT ctrl_DIV md_capture md_timeout
   localparam logic [8:0] SFD  = 9'b100000000;
   localparam logic [8:0] SDX  = 9'b010000000;
   localparam logic [8:0] NFD  = 9'b001000000;
   localparam logic [8:0] NDX  = 9'b000100000;
   localparam logic [8:0] NXM  = 9'b000010000;
   localparam logic [8:0] CM   = 9'b000001000;
   localparam logic [8:0] CD   = 9'b000000100;
   localparam logic [8:0] CAP  = 9'b000000010;
   localparam logic [8:0] MDT  = 9'b000000001;
   localparam logic [8:0] LU   = SFD | NDX;
   localparam logic [8:0] HOLD = SFD | SDX | NXM;

   logic        clock, reset, flush, multdiv_ready, multdiv_exception;
   logic [31:0] FDinsn, DXinsn;
   logic        stall_FD, stall_DX, nop_FD, nop_DX, nop_XM;
   logic        ctrl_MULT, ctrl_DIV, md_capture, md_timeout;

   hazard_stall_ctrl #(.MD_TIMEOUT(MdTimeout), .CNT_W(6)) dut (
      .clock            (clock),
      .reset            (reset),
      .FDinsn           (FDinsn),
      .DXinsn           (DXinsn),
      .flush            (flush),
      .multdiv_ready    (multdiv_ready),
      .multdiv_exception(multdiv_exception),
      .stall_FD         (stall_FD),
      .stall_DX         (stall_DX),
      .nop_FD           (nop_FD),
      .nop_DX           (nop_DX),
      .nop_XM           (nop_XM),
      .ctrl_MULT        (ctrl_MULT),
      .ctrl_DIV         (ctrl_DIV),
      .md_capture       (md_capture),
      .md_timeout       (md_timeout)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        rst;
      logic [31:0] fd;
      logic [31:0] dx;
      logic        fl;
      logic        rdy;
      logic [8:0]  exp;
   } vec_t;

   vec_t       vecs[$];
   logic [8:0] expQ[$];
   string      nameQ[$];
   int         nTests  = 0;
   int         nFailed = 0;
   logic       toutExp = 1'b0;

   function automatic logic [31:0] rIns(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] alu);
      return {5'b00000, rd, rs, rt, 5'b00000, alu, 2'b00};
   endfunction

   function automatic logic [31:0] iIns(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs);
      return {op, rd, rs, 17'd0};
   endfunction

   function automatic vec_t mk(input logic rst, input logic [31:0] fd, input logic [31:0] dx,
                               input logic fl, input logic [8:0] exp);
      vec_t v;
      v.rst = rst; v.fd = fd; v.dx = dx; v.fl = fl; v.rdy = 1'b0; v.exp = exp;
      return v;
   endfunction

   task automatic check();
      logic [8:0] got, want;
      string      nm;
      got  = {stall_FD, stall_DX, nop_FD, nop_DX, nop_XM, ctrl_MULT, ctrl_DIV, md_capture,
              md_timeout};
      want = expQ.pop_front();
      nm   = nameQ.pop_front();
      nTests++;
      if (got !== want) begin
         nFailed++;
         $display("FAIL %s @%0t: got %b expected %b", nm, $time, got, want);
      end
   endtask

   task automatic step(input logic rst, input logic [31:0] fd, input logic [31:0] dx,
                       input logic fl, input logic rdy, input logic [8:0] exp, input string nm);
      reset = rst; FDinsn = fd; DXinsn = dx; flush = fl; multdiv_ready = rdy;
      expQ.push_back(rst ? (exp | (toutExp ? MDT : 9'd0)) : 9'd0);
      nameQ.push_back(nm);
      @(negedge clock);
      check();
      @(posedge clock);
      #1;
      if (!rst) toutExp = 1'b0;
   endtask

   // readyAt: WAIT cycle on which ready pulses; 0 means never (timeout path).
   task automatic runMd(input logic [31:0] ins, input logic isDiv, input int readyAt,
                        input logic [31:0] fd);
      step(1'b1, fd, ins, 1'b0, 1'b0, HOLD | (isDiv ? CD : CM), "md start");
      for (int k = 1; k <= MdTimeout; k++) begin
         logic r, last;
         r    = (k == readyAt);
         last = r || (k == MdTimeout);
         step(1'b1, fd, ins, (k == 2), r, HOLD | (last ? CAP : 9'd0), "md wait");
         if (last) begin
            if (!r) toutExp = 1'b1;
            break;
         end
      end
      step(1'b1, fd, ins, 1'b0, 1'b0, 9'd0, "md done");
   endtask

   initial begin
      logic [31:0] nop, mul, div, lw5, fdUse, fdFree;
      nop    = 32'd0;
      mul    = rIns(5'd4, 5'd2, 5'd3, 5'b00110);
      div    = rIns(5'd8, 5'd9, 5'd10, 5'b00111);
      lw5    = iIns(OP_LW, 5'd5, 5'd1);
      fdUse  = rIns(5'd6, 5'd5, 5'd2, 5'd0);
      fdFree = rIns(5'd6, 5'd7, 5'd2, 5'd0);
      multdiv_exception = 1'b0;

      vecs.push_back(mk(1'b0, fdUse, mul, 1'b1, 9'd0));
      vecs.push_back(mk(1'b0, fdUse, lw5, 1'b0, 9'd0));
      vecs.push_back(mk(1'b1, fdUse, lw5, 1'b0, LU));
      vecs.push_back(mk(1'b1, fdUse, nop, 1'b0, 9'd0));
      vecs.push_back(mk(1'b1, fdFree, lw5, 1'b0, 9'd0));
      vecs.push_back(mk(1'b1, rIns(5'd6, 5'd7, 5'd5, 5'd0), lw5, 1'b0, LU));
      vecs.push_back(mk(1'b1, iIns(OP_SW, 5'd5, 5'd3), lw5, 1'b0, 9'd0));
      vecs.push_back(mk(1'b1, iIns(OP_SW, 5'd3, 5'd5), lw5, 1'b0, LU));
      vecs.push_back(mk(1'b1, rIns(5'd6, 5'd0, 5'd2, 5'd0), iIns(OP_LW, 5'd0, 5'd1), 1'b0, 9'd0));
      vecs.push_back(mk(1'b1, iIns(OP_BNE, 5'd5, 5'd1), lw5, 1'b0, LU));
      vecs.push_back(mk(1'b1, iIns(OP_JR, 5'd5, 5'd0), lw5, 1'b0, LU));
      vecs.push_back(mk(1'b1, {5'b10110, 27'd0}, iIns(OP_LW, 5'd30, 5'd1), 1'b0, LU));
      vecs.push_back(mk(1'b1, iIns(OP_ADDI, 5'd6, 5'd5), lw5, 1'b0, LU));
      vecs.push_back(mk(1'b1, iIns(OP_ADDI, 5'd5, 5'd2), lw5, 1'b0, 9'd0));
      vecs.push_back(mk(1'b1, iIns(OP_J, 5'd5, 5'd5), lw5, 1'b0, 9'd0));
      vecs.push_back(mk(1'b1, fdUse, lw5, 1'b1, NFD | NDX));
      vecs.push_back(mk(1'b1, fdFree, mul, 1'b1, NFD | NDX));
      vecs.push_back(mk(1'b1, fdFree, nop, 1'b0, 9'd0));

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].fd, vecs[i].dx, vecs[i].fl, vecs[i].rdy, vecs[i].exp,
              $sformatf("vec%0d", i));
      end

      // mul answered on the 17th WAIT cycle: 18 stalled cycles then a clean DONE
      runMd(mul, 1'b0, 17, fdFree);
      step(1'b1, fdFree, nop, 1'b0, 1'b0, 9'd0, "after mul");

      // back-to-back div then mul
      runMd(div, 1'b1, 3, fdFree);
      runMd(mul, 1'b0, 2, fdFree);

      // reset in WAIT, late ready ignored, fresh start still works
      step(1'b1, fdFree, mul, 1'b0, 1'b0, HOLD | CM, "rst start");
      step(1'b1, fdFree, mul, 1'b0, 1'b0, HOLD, "rst wait1");
      step(1'b1, fdFree, mul, 1'b0, 1'b0, HOLD, "rst wait2");
      step(1'b0, fdFree, mul, 1'b0, 1'b1, 9'd0, "rst in wait");
      step(1'b1, fdFree, nop, 1'b0, 1'b1, 9'd0, "ready after rst");
      runMd(mul, 1'b0, 1, fdFree);

      // ready on the timeout cycle wins: no sticky flag
      runMd(mul, 1'b0, MdTimeout, fdFree);
      step(1'b1, fdFree, nop, 1'b0, 1'b0, 9'd0, "ready beats timeout");

      // genuine timeout
      runMd(mul, 1'b0, 0, fdFree);
      step(1'b1, fdFree, nop, 1'b0, 1'b0, 9'd0, "timeout sticky");
      step(1'b1, fdUse, lw5, 1'b0, 1'b0, LU, "timeout sticky lu");
      step(1'b0, fdFree, nop, 1'b0, 1'b0, 9'd0, "timeout reset");
      step(1'b1, fdFree, nop, 1'b0, 1'b0, 9'd0, "timeout cleared");

      $display("[TB] %0d tests run, %0d failed", nTests, nFailed);
      $finish;
   end

endmodule
